// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// One shared 2*WIDTH accumulator serves both the shift-add multiplier and the
// restoring divider. Operands are reduced to magnitudes on entry, and the sign
// is restored in a single FIX cycle. The result is presented as a one-cycle
// HI/LO write pulse.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             stall_req,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = 6;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi, lo} working register
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               in_sign_a, in_sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;
    logic               div_by_zero;

    // Operand magnitudes and one iteration step for both algorithms.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves a variable unassigned would infer a latch.
        in_sign_a = op_signed & src_a[WIDTH-1];
        in_sign_b = op_signed & src_b[WIDTH-1];
        mag_a     = in_sign_a ? -src_a : src_a;
        mag_b     = in_sign_b ? -src_b : src_b;

        // Shift-add: add the multiplicand into the upper half when the
        // current multiplier bit (acc[0]) is set, then shift right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: trial-subtract the divisor from the shifted
        // remainder; keep it and shift in a 1 if no borrow.
        div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
        div_next = div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        // Sign correction applied in FIX. A zero divisor yields an all-ones
        // quotient and a remainder equal to the original dividend.
        prod_fix    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot        = acc_q[WIDTH-1:0];
        rem         = acc_q[2*WIDTH-1:WIDTH];
        div_by_zero = (opnd_q == '0);
        quot_fix    = div_by_zero ? '1 : ((sign_a_q ^ sign_b_q) ? -quot : quot);
        rem_fix     = sign_a_q ? -rem : rem;
    end

    // Next-state and next-register computation for the control FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div_d    = div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    div_d    = op_div;
                    opnd_d   = op_div ? mag_b : mag_a;
                    acc_d    = op_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                end
            end
            S_CALC: begin
                acc_d = div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush overrides everything: back to IDLE, no pulse, results kept.
        if (cancel) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Stall from the accepted start cycle through FIX; released in DONE.
    always_comb begin
        stall_req = !rst & (((state_q == S_IDLE) & start & !cancel)
                            | (state_q == S_CALC) | (state_q == S_FIX));
    end

    assign done  = done_q;
    assign hi_we = done_q;
    assign lo_we = done_q;
    assign hi_o  = hi_q;
    assign lo_o  = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: a table of operations with hand-computed
// HI/LO results, followed by cancel, reset, and back-to-back sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_div;
    logic        op_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stall_req;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_div    (op_div),
        .op_signed (op_signed),
        .src_a     (src_a),
        .src_b     (src_b),
        .cancel    (cancel),
        .stall_req (stall_req),
        .done      (done),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        op_div;
        logic        op_signed;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and return in the negedge of the done cycle.
    task automatic run_op(input logic d, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int stall_n);
        @(negedge clk);
        check("done_low_before_start", {63'b0, done}, 64'd0);
        op_div    = d;
        op_signed = s;
        src_a     = a;
        src_b     = b;
        start     = 1'b1;
        #1;
        stall_n = stall_req ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        src_a = ~a;   // operands must only be sampled in IDLE
        src_b = ~b;
        lat   = 1;
        while (!done && lat < 100) begin
            if (stall_req) stall_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int stall_n,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_stall_cycles"}, 64'(stall_n), 64'd34);
        check({tag, "_stall_in_done"}, {63'b0, stall_req}, 64'd0);
        check({tag, "_we"}, {62'b0, hi_we, lo_we}, 64'd3);
        check({tag, "_hi"}, {32'b0, hi_o}, {32'b0, exp_hi});
        check({tag, "_lo"}, {32'b0, lo_o}, {32'b0, exp_lo});
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        int stall_n;
        int seen_done;
        int c1;
        int c2;

        //                op_div signed  a             b             hi            lo
        vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{1'b1, 1'b0, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[5]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7]  = '{1'b1, 1'b0, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[8]  = '{1'b1, 1'b1, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[9]  = '{1'b0, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[10] = '{1'b1, 1'b1, 32'hFFFFEDCC, 32'h00000000, 32'hFFFFEDCC, 32'hFFFFFFFF};

        rst       = 1'b1;
        start     = 1'b0;
        cancel    = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        src_a     = '0;
        src_b     = '0;

        // Reset state.
        #2;
        check("reset_hi", {32'b0, hi_o}, 64'd0);
        check("reset_lo", {32'b0, lo_o}, 64'd0);
        check("reset_flags", {60'b0, done, hi_we, lo_we, stall_req}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op_div, vecs[i].op_signed, vecs[i].a, vecs[i].b, lat, stall_n);
            check_result($sformatf("vec%0d", i), lat, stall_n, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // start and cancel together in IDLE: cancel wins.
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        #1;
        check("start_cancel_stall", {63'b0, stall_req}, 64'd0);
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        check("start_cancel_stays_idle", {63'b0, stall_req}, 64'd0);

        // DIVU cancelled at iteration 10; prior result (vec10) must survive.
        @(negedge clk);
        op_div    = 1'b1;
        op_signed = 1'b0;
        src_a     = 32'd100;
        src_b     = 32'd7;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        seen_done = 0;
        for (int k = 1; k < 11; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_stall_drop", {63'b0, stall_req}, 64'd0);
        check("cancel_no_done", 64'(seen_done) + {63'b0, done}, 64'd0);
        check("cancel_hi_kept", {32'b0, hi_o}, 64'hFFFFEDCC);
        check("cancel_lo_kept", {32'b0, lo_o}, 64'hFFFFFFFF);
        run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, stall_n);
        check_result("after_cancel", lat, stall_n, 32'd2, 32'd14);

        // MULTU interrupted by reset at iteration 20.
        @(negedge clk);
        op_div    = 1'b0;
        op_signed = 1'b0;
        src_a     = 32'd5;
        src_b     = 32'd6;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 21; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_hi", {32'b0, hi_o}, 64'd0);
        check("midreset_lo", {32'b0, lo_o}, 64'd0);
        check("midreset_flags", {60'b0, done, hi_we, lo_we, stall_req}, 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("midreset_no_done", 64'(seen_done), 64'd0);
        run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, stall_n);
        check_result("after_reset", lat, stall_n, 32'd0, 32'd1);

        // Back-to-back: MULTU, then DIVU started in the cycle after DONE.
        run_op(1'b0, 1'b0, 32'h00010000, 32'h00010000, lat, stall_n);
        c1 = cyc;
        check_result("b2b_mul", lat, stall_n, 32'd1, 32'd0);
        run_op(1'b1, 1'b0, 32'd1000, 32'd10, lat, stall_n);
        c2 = cyc;
        check_result("b2b_div", lat, stall_n, 32'd0, 32'd100);
        check("b2b_spacing", 64'(c2 - c1), 64'd35);

        @(negedge clk);
        check("done_single_cycle", {63'b0, done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the EX stage; it produces the HI/LO results that the EX stage forwards to ID and writes back to the HI/LO registers. It executes MULT, MULTU, DIV and DIVU over 34 cycles on one shared shift/add datapath. While it works it stalls the pipeline, and it presents the 64-bit result as a one-cycle write pulse.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request from EX; sampled only in IDLE.
- op_div  input  1  1 = divide, 0 = multiply.
- op_signed  input  1  1 = signed (MULT/DIV), 0 = unsigned.
- src_a  input  WIDTH  multiplicand / dividend.
- src_b  input  WIDTH  multiplier / divisor.
- cancel  input  1  pipeline flush; aborts any operation.
- stall_req  output  1  holds EX and earlier stages.
- done  output  1  result valid this cycle.
- hi_we  output  1  equals done.
- lo_we  output  1  equals done.
- hi_o  output  WIDTH  MUL: product[63:32]; DIV: remainder.
- lo_o  output  WIDTH  MUL: product[31:0]; DIV: quotient.

## Operation
States and transitions:
- IDLE: wait for start.
  - start & !cancel -> CALC.
  - Capture |src_a| and |src_b| (two's-complement magnitude when op_signed, raw otherwise).
  - Capture the sign flags, op_div and op_signed.
  - Clear the 6-bit iteration counter.
- CALC: one iteration per cycle, counter increments.
  - After the 32nd iteration (counter = 31) -> FIX.
  - MUL: shift-add, 64-bit accumulator.
  - DIV: restoring; shift remainder:dividend left, subtract divisor, keep the result if non-negative and set the quotient bit.
- FIX: apply sign correction and latch the results into hi_o/lo_o -> DONE.
  - MUL: negate the 64-bit product if sign_a ^ sign_b (signed only).
  - DIV: negate the quotient if sign_a ^ sign_b; negate the remainder if sign_a (signed only).
- DONE: done = hi_we = lo_we = 1 for exactly one cycle -> IDLE.

Output rules:
- stall_req = !rst & ((IDLE & start & !cancel) | CALC | FIX); it is 0 in DONE, so EX advances and captures the result.
- hi_o/lo_o hold their last result until the next FIX; they never change in other states.

Boundary conditions:
- Divide by zero (src_b = 0, signed or unsigned): lo_o = all ones, hi_o = src_a. Sign correction is bypassed; latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo_o = 0x80000000, hi_o = 0.
- MUL with 0x80000000 operands is exact (magnitudes are WIDTH-bit unsigned).
- Flush and restart:
  - cancel in any state -> IDLE on the next edge; done is suppressed; hi_o/lo_o are unchanged.
  - cancel and start together in IDLE: cancel wins.
  - start outside IDLE is ignored; operand inputs are only sampled in IDLE.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after DONE.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, done = hi_we = lo_we = 0, hi_o = lo_o = 0, stall_req = 0.
- A mid-operation reset discards the operation; no done pulse follows.
- Latency: start sampled at edge E0.
  - CALC occupies the cycles after E0..E31.
  - FIX is the cycle after E32.
  - DONE is the cycle after E33, so done is high 34 cycles after the start cycle.
  - The result is visible on hi_o/lo_o from DONE onward.
- stall_req is high from the start cycle through the FIX cycle inclusive (34 cycles), low in DONE.
- Cancel latency: stall_req drops in the cycle after cancel is sampled.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi_o = 0xFFFFFFFE, lo_o = 0x00000001. Check:
  - done/hi_we/lo_we high for exactly one cycle, 34 cycles after start.
  - stall_req high for the 34 preceding cycles, low in the done cycle.
- MULT −3 × 7 -> hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 -> hi_o = 0x40000000, lo_o = 0x00000000.
- DIV −7 / 2 -> lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF.
- DIVU 7 / 2 -> lo_o = 3, hi_o = 1.
- DIV 7 / −2 -> lo_o = 0xFFFFFFFD, hi_o = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_o = 0x80000000, hi_o = 0.
- DIVU 0x1234 / 0 and DIV 0x1234 / 0 -> lo_o = 0xFFFFFFFF, hi_o = 0x1234.
- Start DIVU, cancel at iteration 10:
  - no done pulse; stall_req low on the next cycle; hi_o/lo_o retain the prior result.
  - a new start one cycle later completes normally.
- Start MULTU, assert rst at iteration 20 -> all outputs 0 immediately, no done pulse; a post-reset start completes with correct results.
- Back-to-back MULTU then DIVU, second start in the cycle after DONE -> two correct results, 35 cycles apart.
